// File: rtl/prog_mux_array.sv
// ---------------------------------------------------------------------------
// prog_mux_array
//   Bank of N_OUT independent N_IN:1 multiplexers whose selects are loaded
//   serially over a daisy-chained programming shift chain. Incoming bits are
//   collected in a shadow shift register. They reach the active select
//   register only on an accepted commit, so routing never changes while a
//   load is in progress.
//
//   Optional feature macro: PROG_PARITY_EN
//     defined   : the chain is one bit longer. The last-shifted bit is an
//                 even-parity bit, and a commit is accepted only when the XOR
//                 over the whole chain is 0.
//     undefined : no integrity check.
//
// Ports
//   prog_clk_i     programming clock; all state changes on its rising edge
//   prog_rst_i     asynchronous active-high reset
//   in_i           fabric data inputs shared by every mux
//   out_o          out_o[j] = in_i[sel_j]; 0 when sel_j is out of range
//   prog_in_i      serial configuration bit
//   prog_en_i      shift enable
//   prog_commit_i  request a shadow -> active transfer
//   prog_out_o     shift-chain MSB, feeds prog_in_i of the next tile
//   prog_ready_o   chain holds a complete image (count saturated)
//   prog_err_o     sticky protocol/integrity error, cleared by accepted commit
// ---------------------------------------------------------------------------
module prog_mux_array #(
  parameter int unsigned N_IN  = 16,
  parameter int unsigned N_OUT = 4
) (
  input  logic             prog_clk_i,
  input  logic             prog_rst_i,
  input  logic [N_IN-1:0]  in_i,
  output logic [N_OUT-1:0] out_o,
  input  logic             prog_in_i,
  input  logic             prog_en_i,
  input  logic             prog_commit_i,
  output logic             prog_out_o,
  output logic             prog_ready_o,
  output logic             prog_err_o
);

  localparam int unsigned SEL_W = $clog2(N_IN);
  localparam int unsigned CFG_W = N_OUT * SEL_W;
`ifdef PROG_PARITY_EN
  localparam int unsigned CHAIN_W = CFG_W + 1;
`else
  localparam int unsigned CHAIN_W = CFG_W;
`endif
  localparam int unsigned CNT_W = $clog2(CHAIN_W + 1);
  localparam int unsigned PAD_W = 1 << SEL_W;
  localparam logic [CNT_W-1:0] CntFull = CNT_W'(CHAIN_W);

  // Load progress, derived from the bit count rather than stored separately.
  typedef enum logic [1:0] {
    StEmpty,
    StLoading,
    StFull
  } load_state_e;

  logic [CHAIN_W-1:0] sh_q, sh_d;
  logic [CFG_W-1:0]   active_q, active_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  load_state_e        load_state;
  logic               parity_ok;
  logic               commit_ok;
  logic [CFG_W-1:0]   payload;

  // ---------------------------------------------------------------------------
  // Load status
  // ---------------------------------------------------------------------------
  always_comb begin
    load_state = StLoading;
    if (cnt_q == '0) begin
      load_state = StEmpty;
    end else if (cnt_q == CntFull) begin
      load_state = StFull;
    end
  end

  // The first-shifted bit ends up at the chain MSB, which is the MSB of the
  // highest mux's select; a parity bit, if any, sits below the payload.
  assign payload = sh_q[CHAIN_W-1 -: CFG_W];

`ifdef PROG_PARITY_EN
  assign parity_ok = ~(^sh_q);
`else
  assign parity_ok = 1'b1;
`endif

  // A commit that arrives together with a shift is refused: the image it
  // would copy is being modified on the same edge.
  assign commit_ok = prog_commit_i && !prog_en_i && (load_state == StFull) && parity_ok;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    sh_d     = sh_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    err_d    = err_q;

    // The chain keeps moving while enabled even when already full, so a
    // tile can pass a longer stream through to its neighbours.
    if (prog_en_i) begin
      sh_d = {sh_q[CHAIN_W-2:0], prog_in_i};
      if (cnt_q != CntFull) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (commit_ok) begin
      active_d = payload;
      cnt_d    = '0;
      err_d    = 1'b0;
    end else if (prog_commit_i) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge prog_clk_i or posedge prog_rst_i) begin
    if (prog_rst_i) begin
      sh_q     <= '0;
      active_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      sh_q     <= sh_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Mux bank
  // ---------------------------------------------------------------------------
  // Inputs are zero-extended to a power of two so that select codes at or
  // above N_IN read a constant 0 instead of indexing past the vector.
  logic [PAD_W-1:0] in_pad;

  always_comb begin
    in_pad           = '0;
    in_pad[N_IN-1:0] = in_i;
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_mux
    logic [SEL_W-1:0] sel;
    assign sel      = active_q[j*SEL_W +: SEL_W];
    assign out_o[j] = in_pad[sel];
  end

  // ---------------------------------------------------------------------------
  // Status outputs
  // ---------------------------------------------------------------------------
  assign prog_out_o   = sh_q[CHAIN_W-1];
  assign prog_ready_o = (load_state == StFull);
  assign prog_err_o   = err_q;

endmodule

// File: tb/tb_prog_mux_array.sv
// ---------------------------------------------------------------------------
// tb_prog_mux_array
//   Drives two instances in parallel from one programming stream: a 16-input
//   bank and a 12-input bank (same chain length), the latter exercising
//   out-of-range selects. A reference model predicts every output; predictions
//   are queued when stimulus is applied and compared when outputs are sampled.
// ---------------------------------------------------------------------------
module tb_prog_mux_array;

`ifdef PROG_PARITY_EN
  localparam int unsigned ChainW = 17;
`else
  localparam int unsigned ChainW = 16;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] in_v;
  logic        prog_in;
  logic        prog_en;
  logic        prog_commit;
  logic [3:0]  out16;
  logic [3:0]  out12;
  logic        po16, po12, rdy16, rdy12, err16, err12;

  prog_mux_array #(.N_IN(16), .N_OUT(4)) u_dut16 (
    .prog_clk_i   (clk),
    .prog_rst_i   (rst),
    .in_i         (in_v),
    .out_o        (out16),
    .prog_in_i    (prog_in),
    .prog_en_i    (prog_en),
    .prog_commit_i(prog_commit),
    .prog_out_o   (po16),
    .prog_ready_o (rdy16),
    .prog_err_o   (err16)
  );

  prog_mux_array #(.N_IN(12), .N_OUT(4)) u_dut12 (
    .prog_clk_i   (clk),
    .prog_rst_i   (rst),
    .in_i         (in_v[11:0]),
    .out_o        (out12),
    .prog_in_i    (prog_in),
    .prog_en_i    (prog_en),
    .prog_commit_i(prog_commit),
    .prog_out_o   (po12),
    .prog_ready_o (rdy12),
    .prog_err_o   (err12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [3:0] out16;
    logic [3:0] out12;
    logic       po;
    logic       rdy;
    logic       err;
  } exp_t;

  exp_t              sb_q[$];
  logic [ChainW-1:0] sh_m;
  logic [15:0]       act_m;
  int unsigned       cnt_m;
  logic              err_m;

  function automatic logic [3:0] mux_m(input logic [15:0] act, input logic [15:0] d,
                                       input int unsigned n);
    logic [3:0] r;
    logic [3:0] sel;
    for (int j = 0; j < 4; j++) begin
      sel  = act[j*4 +: 4];
      r[j] = (int'(sel) < int'(n)) ? d[sel] : 1'b0;
    end
    return r;
  endfunction

  function automatic logic [ChainW-1:0] mk_chain(input logic [15:0] p, input logic par);
`ifdef PROG_PARITY_EN
    return {p, par};
`else
    return p ^ {15'b0, par & 1'b0};
`endif
  endfunction

  task automatic model_reset();
    sh_m  = '0;
    act_m = '0;
    cnt_m = 0;
    err_m = 1'b0;
  endtask

  task automatic push_exp();
    exp_t e;
    e.out16 = mux_m(act_m, in_v, 16);
    e.out12 = mux_m(act_m, {4'b0, in_v[11:0]}, 12);
    e.po    = sh_m[ChainW-1];
    e.rdy   = (cnt_m == ChainW);
    e.err   = err_m;
    sb_q.push_back(e);
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_val({tag, "_out16"}, 32'(out16), 32'(e.out16));
      check_val({tag, "_out12"}, 32'(out12), 32'(e.out12));
      check_val({tag, "_po"},    32'(po16),  32'(e.po));
      check_val({tag, "_rdy"},   32'(rdy16), 32'(e.rdy));
      check_val({tag, "_err"},   32'(err16), 32'(e.err));
      check_val({tag, "_err12"}, 32'(err12), 32'(e.err));
    end
  endtask

  // One programming clock: inputs driven at negedge, model updated at the
  // posedge, outputs compared at the following negedge.
  task automatic step(input logic en, input logic bitv, input logic com, input string tag);
    logic full, ok, acc;
    prog_en     = en;
    prog_in     = bitv;
    prog_commit = com;
    @(posedge clk);
    full = (cnt_m == ChainW);
`ifdef PROG_PARITY_EN
    ok = ~(^sh_m);
`else
    ok = 1'b1;
`endif
    acc = com && !en && full && ok;
    if (acc) begin
      act_m = sh_m[ChainW-1 -: 16];
      cnt_m = 0;
      err_m = 1'b0;
    end else if (com) begin
      err_m = 1'b1;
    end
    if (en) begin
      sh_m = {sh_m[ChainW-2:0], bitv};
      if (cnt_m < ChainW) cnt_m++;
    end
    push_exp();
    @(negedge clk);
    pop_cmp(tag);
  endtask

  task automatic set_in(input logic [15:0] v, input string tag);
    in_v = v;
    #1;
    push_exp();
    pop_cmp(tag);
  endtask

  task automatic shift_bits(input logic [ChainW-1:0] w, input int hi, input int lo,
                            input string tag);
    for (int i = hi; i >= lo; i--) step(1'b1, w[i], 1'b0, tag);
  endtask

  task automatic commit(input string tag);
    step(1'b0, 1'b0, 1'b1, tag);
  endtask

  task automatic pulse_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    push_exp();
    pop_cmp(tag);
    rst = 1'b0;
    #1;
  endtask

  logic [ChainW-1:0] w;

  initial begin
    rst         = 1'b1;
    in_v        = 16'h0001;
    prog_in     = 1'b0;
    prog_en     = 1'b0;
    prog_commit = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset state: every mux selects in[0].
    check_val("rst_out16", 32'(out16), 32'h0000_000F);
    check_val("rst_po",    32'(po16),  32'd0);
    check_val("rst_rdy",   32'(rdy16), 32'd0);
    check_val("rst_err",   32'(err16), 32'd0);
    rst = 1'b0;
    #1;

    // Partial load then asynchronous reset.
    shift_bits(mk_chain(16'hFFFF, 1'b0), ChainW - 1, ChainW - 7, "load7");
    pulse_reset("rst_mid");

    // Full load and commit.
    w = mk_chain(16'h3A50, ^16'h3A50);
    shift_bits(w, ChainW - 1, 0, "ld3a50");
    check_val("ld3a50_ready", 32'(rdy16), 32'd1);
    commit("cm3a50");
    check_val("cm3a50_ready", 32'(rdy16), 32'd0);
    set_in(16'h0408, "in0408");
    check_val("in0408_out", 32'(out16), 32'h0000_000C);

    // Premature commit is refused; completing the load then succeeds.
    w = mk_chain(16'hD1E7, ^16'hD1E7);
    shift_bits(w, ChainW - 1, ChainW - 10, "ldd1e7a");
    commit("early");
    check_val("early_err", 32'(err16), 32'd1);
    check_val("early_out", 32'(out16), 32'h0000_000C);
    shift_bits(w, ChainW - 11, 0, "ldd1e7b");
    commit("cmd1e7");
    check_val("cmd1e7_err", 32'(err16), 32'd0);
    set_in(16'hFFFF, "inffff");
    check_val("oor_out12", 32'(out12), 32'h0000_0005);
    check_val("oor_out16", 32'(out16), 32'h0000_000F);

    // prog_out follows the chain MSB and the chain keeps shifting when full.
    w = mk_chain(16'h8000, 1'b1);
    shift_bits(w, ChainW - 1, 0, "ld8000");
    check_val("ld8000_po", 32'(po16), 32'd1);
    step(1'b1, 1'b0, 1'b0, "extra");
    check_val("extra_po",  32'(po16),  32'd0);
    check_val("extra_rdy", 32'(rdy16), 32'd1);

    // Commit while shifting is rejected.
    step(1'b1, 1'b1, 1'b1, "cmsh");
    check_val("cmsh_err", 32'(err16), 32'd1);
    check_val("cmsh_out", 32'(out16), 32'h0000_000F);

    // Several more patterns through the scoreboard.
    for (int k = 0; k < 3; k++) begin
      logic [15:0] p;
      p = 16'($urandom);
      shift_bits(mk_chain(p, ^p), ChainW - 1, 0, "rnd_ld");
      commit("rnd_cm");
      set_in(16'($urandom), "rnd_in");
    end

`ifdef PROG_PARITY_EN
    shift_bits(mk_chain(16'h0001, 1'b1), ChainW - 1, 0, "par_good");
    commit("par_good_cm");
    check_val("par_good_err", 32'(err16), 32'd0);
    shift_bits(mk_chain(16'h0001, 1'b0), ChainW - 1, 0, "par_bad");
    commit("par_bad_cm");
    check_val("par_bad_err", 32'(err16), 32'd1);
`endif

    // Reset with a nonzero active config and a partial load pending.
    shift_bits(mk_chain(16'h1234, 1'b0), ChainW - 1, ChainW - 5, "ld_part");
    pulse_reset("rst_final");
    set_in(16'h0001, "final_in");
    check_val("final_out16", 32'(out16), 32'h0000_000F);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
